cpu_core_param: RTL and testbench
=================================

Name: cpu_core_param

Overview:
- Parametrised successor to the 14-bit multicycle three-address machine: same memory-to-memory instruction model {op, a, b, c}, generalised in data/address width.
- Adds async active-low reset, a run/idle control and a req/ack memory handshake tolerating any latency.
- Adds a conditional branch (JZ) and an output strobe.
- Sits between a single shared instruction/data memory and the board I/O register.

Parameters:
- AW, 4, address width; memory holds 2^AW words; PC is AW bits.
- OPW, 2, opcode width; only values 0-3 are decoded, others execute as NOP.
- DW, OPW+3*AW (14), data/instruction width; instruction fields are op=[DW-1:3AW], a=[3AW-1:2AW], b=[2AW-1:AW], c=[AW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid in the ack cycle.
- mem_ack  in  1  request completion.
- io_data  out  DW  last OUT value.
- io_valid  out  1  one-cycle strobe on OUT.
- busy  out  1  high in every state except IDLE.
- pc  out  AW  current program counter.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pc=0; ir, opa, opb, res=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; io_data=0; io_valid=0; sat_flag=0.
- Handshake:
  - Exactly one outstanding request.
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack=1.
  - mem_ack is legal in the same cycle req is first high (zero-latency memory) or any later cycle.
  - mem_ack while mem_req=0 is ignored.
  - mem_req drops the cycle after ack, unless the next state issues a new request; back-to-back requests are allowed.
- Opcodes:
  - 0 ADD: mem[c] = mem[a] + mem[b].
  - 1 SUB: mem[c] = mem[a] - mem[b].
  - 2 OUT: io_data = mem[a].
  - 3 JZ: if mem[a]==0 then pc = c.
- FSM:
  - IDLE: run=1 -> FETCH; pc held.
  - FETCH: read pc; on ack ir<=rdata, pc<=pc+1 (mod 2^AW; 15 wraps to 0) -> RD_A.
  - RD_A: read a; on ack opa<=rdata. ADD/SUB -> RD_B; others -> EXEC.
  - RD_B: read b; on ack opb<=rdata -> EXEC.
  - EXEC: single cycle, no memory access.
    - ADD/SUB: res<=ALU -> WR_C.
    - OUT: io_data<=opa, io_valid=1 for this one cycle -> next.
    - JZ: if opa==0 then pc<=c -> next.
  - WR_C: write res to c; on ack -> next.
  - "next" = FETCH if run=1 that cycle, else IDLE.
- Latency with zero-wait memory: ADD/SUB 5 cycles, OUT/JZ 3 cycles.
- Dropping run mid-instruction never aborts; the instruction completes including its write.
- Arithmetic is unsigned modulo 2^DW unless CPU_SAT_EN is defined.
- A write to the address holding the next instruction is self-modifying and legal; the new word is fetched.
- Reset asserted mid-request drops mem_req immediately; the memory must tolerate an abandoned write.

Optional Feature:
- Macro: CPU_SAT_EN.
- Defined:
  - ADD clamps at 2^DW-1.
  - SUB clamps at 0.
  - Any clamp sets sat_flag; it stays set until reset.
- Undefined:
  - Results wrap.
  - sat_flag is tied 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_OUT=2, OP_JZ=3;
  - state encoding IDLE/FETCH/RD_A/RD_B/EXEC/WR_C;
  - field-slice helper functions.
- One sub-module, cpu_alu: combinational, parametrised by DW, with inputs a, b, op and outputs res, sat. Saturation logic is confined to it.

Test Plan (defaults AW=4, OPW=2, DW=14; zero-wait memory unless noted):
- mem[0]=14'h0123, mem[1]=5, mem[2]=7, run=1 -> write to addr 3 with data 12 exactly 5 cycles after FETCH entry; then pc=1.
- mem[0]=14'h1123, mem[1]=3, mem[2]=5:
  - without CPU_SAT_EN -> mem[3]=14'h3FFE, sat_flag=0;
  - with CPU_SAT_EN -> mem[3]=0, sat_flag=1.
- mem[0]=14'h2400 (OUT a=4), mem[4]=14'h1ABC -> io_valid high exactly 1 cycle with io_data=14'h1ABC; no memory write issued.
- JZ: mem[0]=14'h350A, mem[5]=0 -> next fetch at addr 10. Same with mem[5]=1 -> next fetch at addr 1. pc=15 fetch -> pc wraps to 0.
- Memory ack delayed 3 cycles on every request -> ADD takes 13 cycles; req/addr/we/wdata stay stable until ack; result identical to the zero-wait case.
- Control and reset:
  - run dropped during RD_B -> write still completes, then IDLE with busy=0; run reasserted -> resumes at the saved pc.
  - rst_n pulsed low during WR_C -> mem_req=0 and pc=0 immediately.

Source files
------------

// File: rtl/cpu_core_param_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared definitions for the parametrised three-address CPU.
//   - opcode values (OP_ADD/OP_SUB/OP_OUT/OP_JZ)
//   - FSM state encoding (cpu_state_e)
//   - field(): generic bit-field extraction used to slice {op,a,b,c}
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_OUT = 2;
  localparam int OP_JZ  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    RD_A  = 3'd2,
    RD_B  = 3'd3,
    EXEC  = 3'd4,
    WR_C  = 3'd5
  } cpu_state_e;

  // Extract 'width' bits starting at 'lsb' from a zero-extended word.
  // Callers size-cast the result down to the field width.
  function automatic logic [63:0] field(input logic [63:0] word,
                                        input int unsigned lsb,
                                        input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// ---------------------------------------------------------------------------
// cpu_core_param_if: memory bus between the CPU (master) and the shared
// instruction/data memory (slave).
//   mem_req   master->slave  request
//   mem_we    master->slave  1 = write, 0 = read
//   mem_addr  master->slave  word address (AW bits)
//   mem_wdata master->slave  write data (DW bits)
//   mem_rdata slave->master  read data, valid in the ack cycle
//   mem_ack   slave->master  request completion
//
// Handshake: one request outstanding at a time. The master holds mem_req,
// mem_we, mem_addr and mem_wdata stable from the cycle mem_req rises until
// the cycle mem_ack=1; a transfer completes on a rising clock edge where
// mem_req and mem_ack are both 1. mem_ack may already be 1 in the first
// request cycle (zero-wait memory). mem_ack with mem_req=0 means nothing.
// The master may start a new request right after an ack (back-to-back).
// ---------------------------------------------------------------------------
interface cpu_core_param_if #(
  parameter int AW = 4,
  parameter int DW = 14
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cpu_core_param_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu: combinational add/subtract for the CPU.
//   a_i, b_i  DW-bit operands
//   op_i      opcode; OP_SUB subtracts, anything else adds
//   res_o     DW-bit result
//   sat_o     1 when the result was clamped
// Macro CPU_SAT_EN: when defined, ADD clamps at all-ones and SUB clamps at
// zero, flagging sat_o. When undefined, results wrap and sat_o is 0.
// ---------------------------------------------------------------------------
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW  = 14,
  parameter int OPW = 2
) (
  input  logic [DW-1:0]  a_i,
  input  logic [DW-1:0]  b_i,
  input  logic [OPW-1:0] op_i,
  output logic [DW-1:0]  res_o,
  output logic           sat_o
);

  logic is_sub;
  assign is_sub = (op_i == OPW'(OP_SUB));

`ifdef CPU_SAT_EN
  // One extra bit catches carry-out (ADD) or borrow (SUB).
  logic [DW:0] sum_w;
  logic [DW:0] diff_w;

  always_comb begin
    sum_w  = {1'b0, a_i} + {1'b0, b_i};
    diff_w = {1'b0, a_i} - {1'b0, b_i};
    res_o  = '0;
    sat_o  = 1'b0;
    if (is_sub) begin
      if (diff_w[DW]) begin
        res_o = '0;
        sat_o = 1'b1;
      end else begin
        res_o = diff_w[DW-1:0];
      end
    end else begin
      if (sum_w[DW]) begin
        res_o = '1;
        sat_o = 1'b1;
      end else begin
        res_o = sum_w[DW-1:0];
      end
    end
  end
`else
  assign res_o = is_sub ? (a_i - b_i) : (a_i + b_i);
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/cpu_core_param.sv
// ---------------------------------------------------------------------------
// cpu_core_param: multicycle memory-to-memory CPU, instruction {op,a,b,c}.
//   ADD: mem[c]=mem[a]+mem[b]   SUB: mem[c]=mem[a]-mem[b]
//   OUT: io_data=mem[a]         JZ : if mem[a]==0 then pc=c
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   run          1 = execute, 0 = stop at the next instruction boundary
//   mem          cpu_core_param_if.master, req/ack memory bus
//   io_data      last OUT value;  io_valid  one-cycle strobe per OUT
//   busy         1 in every state except IDLE
//   pc           program counter
//   sat_flag     sticky saturation flag (only ever set with CPU_SAT_EN)
//   dbg_state    current FSM state
// Macro CPU_SAT_EN (inside cpu_alu) selects saturating arithmetic.
// ---------------------------------------------------------------------------
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int AW  = 4,
  parameter int OPW = 2,
  parameter int DW  = OPW + 3*AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  cpu_core_param_if.master        mem,
  output logic [DW-1:0]           io_data,
  output logic                    io_valid,
  output logic                    busy,
  output logic [AW-1:0]           pc,
  output logic                    sat_flag,
  output cpu_state_e              dbg_state
);

  cpu_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] io_data_q, io_data_d;
  logic          io_valid_q, io_valid_d;
  logic          sat_q, sat_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ack;
  logic [OPW-1:0] op_f;
  logic [AW-1:0]  c_f;
  logic [AW-1:0]  na_f, nb_f, nc_f;
  logic          is_alu;
  logic [DW-1:0] alu_res;
  logic          alu_sat;

  // An ack only counts while a request is actually outstanding.
  assign ack = mem.mem_ack & req_q;

  // Decode from the latched instruction.
  assign op_f   = OPW'(field(64'(ir_q), 3*AW, OPW));
  assign c_f    = AW'(field(64'(ir_q), 0, AW));
  assign is_alu = (op_f == OPW'(OP_ADD)) || (op_f == OPW'(OP_SUB));

  // Bus addresses come from ir_d so the RD_A address is already correct
  // in the FETCH ack cycle, when the instruction is only arriving.
  assign na_f = AW'(field(64'(ir_d), 2*AW, AW));
  assign nb_f = AW'(field(64'(ir_d), AW, AW));
  assign nc_f = AW'(field(64'(ir_d), 0, AW));

  cpu_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .a_i   (opa_q),
    .b_i   (opb_q),
    .op_i  (op_f),
    .res_o (alu_res),
    .sat_o (alu_sat)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      io_data_q  <= '0;
      io_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_q      <= res_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
      sat_q      <= sat_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (run) state_d = FETCH;
      FETCH: if (ack) state_d = RD_A;
      RD_A:  if (ack) state_d = is_alu ? RD_B : EXEC;
      RD_B:  if (ack) state_d = EXEC;
      EXEC:  state_d = is_alu ? WR_C : (run ? FETCH : IDLE);
      WR_C:  if (ack) state_d = run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered bus outputs for the coming state.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    io_data_d  = io_data_q;
    io_valid_d = 1'b0;
    sat_d      = sat_q;
    case (state_q)
      FETCH: if (ack) begin
        ir_d = mem.mem_rdata;
        pc_d = pc_q + 1'b1;
      end
      RD_A: if (ack) opa_d = mem.mem_rdata;
      RD_B: if (ack) opb_d = mem.mem_rdata;
      EXEC: begin
        if (is_alu) begin
          res_d = alu_res;
          sat_d = sat_q | alu_sat;
        end else if (op_f == OPW'(OP_OUT)) begin
          io_data_d  = opa_q;
          io_valid_d = 1'b1;
        end else if ((op_f == OPW'(OP_JZ)) && (opa_q == '0)) begin
          pc_d = c_f;
        end
      end
      default: ;
    endcase

    // Driving the bus from state_d keeps the request registered yet lets
    // it rise in the very cycle the requesting state is entered.
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      FETCH: begin req_d = 1'b1; addr_d = pc_d; end
      RD_A:  begin req_d = 1'b1; addr_d = na_f; end
      RD_B:  begin req_d = 1'b1; addr_d = nb_f; end
      WR_C:  begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = nc_f;
        wdata_d = res_d;
      end
      default: ;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign io_data   = io_data_q;
  assign io_valid  = io_valid_q;
  assign busy      = (state_q != IDLE);
  assign pc        = pc_q;
  assign sat_flag  = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_core_param.sv
module tb_cpu_core_param;
  import cpu_pkg::*;

`ifdef CPU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  cpu_core_param_if #(.AW(4), .DW(14)) mif ();
  logic [13:0] io_data;
  logic        io_valid, busy, sat_flag;
  logic [3:0]  pc;
  cpu_state_e  dut_state;

  cpu_core_param #(.AW(4), .OPW(2), .DW(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .mem       (mif),
    .io_data   (io_data),
    .io_valid  (io_valid),
    .busy      (busy),
    .pc        (pc),
    .sat_flag  (sat_flag),
    .dbg_state (dut_state)
  );

  // ---------------- memory model ----------------
  logic [13:0] mem [16];
  int          lat = 0;       // extra wait cycles before ack
  int          wcnt = 0;
  int          stab_bad = 0;
  logic        p_valid = 1'b0;
  logic [3:0]  p_addr;
  logic        p_we;
  logic [13:0] p_wdata;

  assign mif.mem_ack   = mif.mem_req && (wcnt == lat);
  assign mif.mem_rdata = mem[mif.mem_addr];

  initial begin
    forever begin
      @(posedge clk);
      if (p_valid && mif.mem_req &&
          (mif.mem_addr !== p_addr || mif.mem_we !== p_we || mif.mem_wdata !== p_wdata))
        stab_bad <= stab_bad + 1;
      p_valid <= mif.mem_req && !mif.mem_ack;
      p_addr  <= mif.mem_addr;
      p_we    <= mif.mem_we;
      p_wdata <= mif.mem_wdata;
      if (mif.mem_req && mif.mem_ack) begin
        if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
        wcnt <= 0;
      end else if (mif.mem_req) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  int          io_cnt = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every io_valid strobe must match the next expected OUT value.
  initial begin
    forever begin
      @(negedge clk);
      if (io_valid) begin
        io_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL io_unexpected: got 0x%0h expected no strobe", io_data);
        end else begin
          check("io_data", 32'(io_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    lat   = 0;
    for (int i = 0; i < 16; i++) mem[i] <= '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_state(input cpu_state_e s, input string name);
    int n = 0;
    while (dut_state != s && n < 200) begin @(negedge clk); n++; end
    if (dut_state != s) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, state %0d expected %0d", name, dut_state, s);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, busy 1 expected 0", name);
    end
  endtask

  // Execute exactly one instruction: run is pulsed so the core stops at
  // the next boundary. Reports busy cycles and the write seen on the bus.
  task automatic run_one(output int cyc, output int wr_at, output int wr_n,
                         output logic [3:0] wa, output logic [13:0] wd);
    cyc = 0; wr_at = 0; wr_n = 0; wa = '0; wd = '0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    while (busy && cyc < 200) begin
      cyc++;
      run = 1'b0;
      if (mif.mem_req && mif.mem_we && mif.mem_ack) begin
        wr_n++;
        wr_at = cyc;
        wa = mif.mem_addr;
        wd = mif.mem_wdata;
      end
      @(negedge clk);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [13:0] inst;
    logic [3:0]  da0;
    logic [13:0] dv0;
    logic [3:0]  da1;
    logic [13:0] dv1;
    int          cyc;
    int          wr_n;
    logic [3:0]  wa;
    logic [13:0] wd;
    int          io_n;
    logic [13:0] io_d;
    logic [3:0]  pc;
    logic        sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc, wr_at, wr_n, io0;
    logic [3:0]  wa;
    logic [13:0] wd;

    //              inst     da0  dv0       da1  dv1      cyc wr  wa    wd                      io io_d     pc    sat
    vecs[0] = '{14'h0123, 4'd1, 14'd5,    4'd2, 14'd7,    5, 1, 4'd3, 14'd12,                 0, 14'h0,    4'd1, 1'b0};
    vecs[1] = '{14'h1123, 4'd1, 14'd3,    4'd2, 14'd5,    5, 1, 4'd3, SAT ? 14'h0 : 14'h3FFE, 0, 14'h0,    4'd1, SAT};
    vecs[2] = '{14'h2400, 4'd4, 14'h1ABC, 4'd4, 14'h1ABC, 3, 0, 4'd0, 14'h0,                  1, 14'h1ABC, 4'd1, 1'b0};
    vecs[3] = '{14'h350A, 4'd5, 14'd0,    4'd5, 14'd0,    3, 0, 4'd0, 14'h0,                  0, 14'h0,    4'd10, 1'b0};
    vecs[4] = '{14'h350A, 4'd5, 14'd1,    4'd5, 14'd1,    3, 0, 4'd0, 14'h0,                  0, 14'h0,    4'd1, 1'b0};
    vecs[5] = '{14'h0123, 4'd1, 14'h3FFF, 4'd2, 14'd2,    5, 1, 4'd3, SAT ? 14'h3FFF : 14'd1, 0, 14'h0,    4'd1, SAT};
    vecs[6] = '{14'h1123, 4'd1, 14'd9,    4'd2, 14'd9,    5, 1, 4'd3, 14'd0,                  0, 14'h0,    4'd1, 1'b0};
    vecs[7] = '{14'h0123, 4'd1, 14'h3FFE, 4'd2, 14'd1,    5, 1, 4'd3, 14'h3FFF,               0, 14'h0,    4'd1, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst_pc",       32'(pc),            32'(0));
    check("rst_req",      32'(mif.mem_req),   32'(0));
    check("rst_we",       32'(mif.mem_we),    32'(0));
    check("rst_addr",     32'(mif.mem_addr),  32'(0));
    check("rst_wdata",    32'(mif.mem_wdata), 32'(0));
    check("rst_io_data",  32'(io_data),       32'(0));
    check("rst_io_valid", 32'(io_valid),      32'(0));
    check("rst_busy",     32'(busy),          32'(0));
    check("rst_sat",      32'(sat_flag),      32'(0));
    check("rst_state",    32'(dut_state),     32'(IDLE));

    // ---- single-instruction vectors, zero-wait memory ----
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mem[0] <= vecs[i].inst;
      mem[vecs[i].da0] <= vecs[i].dv0;
      mem[vecs[i].da1] <= vecs[i].dv1;
      io0 = io_cnt;
      if (vecs[i].io_n != 0) exp_q.push_back(vecs[i].io_d);
      run_one(cyc, wr_at, wr_n, wa, wd);
      check($sformatf("v%0d_cycles", i), 32'(cyc),  32'(vecs[i].cyc));
      check($sformatf("v%0d_writes", i), 32'(wr_n), 32'(vecs[i].wr_n));
      if (vecs[i].wr_n != 0) begin
        check($sformatf("v%0d_wr_at", i),   32'(wr_at), 32'(vecs[i].cyc));
        check($sformatf("v%0d_wr_addr", i), 32'(wa),    32'(vecs[i].wa));
        check($sformatf("v%0d_wr_data", i), 32'(wd),    32'(vecs[i].wd));
        check($sformatf("v%0d_mem", i),     32'(mem[vecs[i].wa]), 32'(vecs[i].wd));
      end
      check($sformatf("v%0d_io_cnt", i), 32'(io_cnt - io0), 32'(vecs[i].io_n));
      check($sformatf("v%0d_pc", i),     32'(pc),       32'(vecs[i].pc));
      check($sformatf("v%0d_sat", i),    32'(sat_flag), 32'(vecs[i].sat));
      check($sformatf("v%0d_idle", i),   32'(busy),     32'(0));
    end

    // ---- ADD with ack in the third cycle of every request ----
    do_reset();
    lat = 2;
    mem[0] <= 14'h0123; mem[1] <= 14'd5; mem[2] <= 14'd7;
    stab_bad = 0;
    run_one(cyc, wr_at, wr_n, wa, wd);
    check("slow_cycles", 32'(cyc),    32'(13));
    check("slow_wr_at",  32'(wr_at),  32'(13));
    check("slow_wr",     32'(wd),     32'(12));
    check("slow_mem",    32'(mem[3]), 32'(12));
    check("slow_pc",     32'(pc),     32'(1));
    check("slow_stable", 32'(stab_bad), 32'(0));

    // ---- run dropped in RD_B: instruction completes, then resumes ----
    do_reset();
    mem[0] <= 14'h0123; mem[1] <= 14'd5; mem[2] <= 14'd7;
    @(negedge clk);
    run = 1'b1;
    wait_state(RD_B, "rdb_wait");
    run = 1'b0;
    wait_idle("rdb_idle");
    check("rdb_mem",   32'(mem[3]), 32'(12));
    check("rdb_pc",    32'(pc),     32'(1));
    check("rdb_state", 32'(dut_state), 32'(IDLE));
    run = 1'b1;
    @(negedge clk);
    check("resume_state", 32'(dut_state),    32'(FETCH));
    check("resume_addr",  32'(mif.mem_addr), 32'(1));
    run = 1'b0;
    wait_idle("resume_idle");
    // mem[1]=5 decodes as ADD a=0 b=0 c=5: 0x0123 + 0x0123
    check("resume_mem", 32'(mem[5]), 32'(14'h0246));
    check("resume_pc",  32'(pc),     32'(2));

    // ---- reset pulsed during WR_C ----
    do_reset();
    lat = 2;
    mem[0] <= 14'h0123; mem[1] <= 14'd5; mem[2] <= 14'd7;
    @(negedge clk);
    run = 1'b1;
    wait_state(WR_C, "wrc_wait");
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check("wrc_req",  32'(mif.mem_req), 32'(0));
    check("wrc_pc",   32'(pc),          32'(0));
    check("wrc_busy", 32'(busy),        32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wrc_abandoned", 32'(mem[3]), 32'(0));

    // ---- JZ to 15, OUT at 15, pc wraps to 0 ----
    do_reset();
    mem[0]  <= 14'h3E0F;   // JZ a=14 c=15, mem[14]=0
    mem[15] <= 14'h2D00;   // OUT a=13
    mem[13] <= 14'h0777;
    exp_q.push_back(14'h0777);
    @(negedge clk);
    run = 1'b1;
    begin
      int n = 0;
      while (!io_valid && n < 100) begin @(negedge clk); n++; end
    end
    check("wrap_io",   32'(io_valid),     32'(1));
    check("wrap_pc",   32'(pc),           32'(0));
    check("wrap_addr", 32'(mif.mem_addr), 32'(0));
    run = 1'b0;
    wait_idle("wrap_idle");
    check("wrap_jz_pc", 32'(pc), 32'(15));

    // ---- self-modifying: ADD rewrites the next instruction ----
    do_reset();
    mem[0] <= 14'h0121;    // ADD a=1 b=2 c=1
    mem[1] <= 14'h2300;    // becomes 0x2400 (OUT a=4)
    mem[2] <= 14'h0100;
    mem[4] <= 14'h0ABC;
    exp_q.push_back(14'h0ABC);
    io0 = io_cnt;
    @(negedge clk);
    run = 1'b1;
    begin
      int n = 0;
      while (!(dut_state == FETCH && pc == 4'd1) && n < 100) begin @(negedge clk); n++; end
    end
    run = 1'b0;
    wait_idle("smc_idle");
    repeat (2) @(negedge clk);
    check("smc_mem",    32'(mem[1]),       32'(14'h2400));
    check("smc_io_cnt", 32'(io_cnt - io0), 32'(1));
    check("smc_pc",     32'(pc),           32'(2));

    // ---- final report ----
    check("io_queue_empty", 32'(exp_q.size()), 32'(0));
    check("stable_all",     32'(stab_bad),     32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
